// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM state types for the default (DECERR) slave.
package axi_pkg;

   localparam int AXI_IDS_BITS  = 8;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_DATA_BITS = 32;
   localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

endpackage

// File: rtl/axi_default_slave_wr.sv
// Write half of the default slave: accepts one AW, sinks W beats until WLAST,
// then answers with a single DECERR B response.
module axi_default_slave_wr
   import axi_pkg::*;
#(
   parameter int ID_W  = AXI_IDS_BITS,
   parameter int LEN_W = AXI_LEN_BITS
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [ID_W-1:0] i_awid,
   input  logic [LEN_W-1:0] i_awlen,
   input  logic            i_awvalid,
   output logic            o_awready,
   input  logic            i_wlast,
   input  logic            i_wvalid,
   output logic            o_wready,
   output logic [ID_W-1:0] o_bid,
   output logic [1:0]      o_bresp,
   output logic            o_bvalid,
   input  logic            i_bready
);

   wr_state_e        r_state;
   logic [LEN_W-1:0] r_wcnt;
   logic [ID_W-1:0]  r_wid;
   logic             r_awready;
   logic             r_wready;
   logic             r_bvalid;
   logic [1:0]       r_bresp;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= W_IDLE;
         r_wcnt    <= '0;
         r_wid     <= '0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            W_IDLE: begin
               if (i_awvalid && r_awready) begin
                  r_state   <= W_DATA;
                  r_wid     <= i_awid;
                  r_wcnt    <= i_awlen;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
               end else begin
                  r_awready <= 1'b1;
               end
            end
            W_DATA: begin
               // WLAST alone ends the burst; the beat count only saturates so a
               // mismatched burst can never wedge the slave.
               if (i_wvalid) begin
                  if (r_wcnt != '0) begin
                     r_wcnt <= r_wcnt - 1'b1;
                  end
                  if (i_wlast) begin
                     r_state  <= W_RESP;
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_bresp  <= RESP_DECERR;
                  end
               end
            end
            W_RESP: begin
               if (i_bready) begin
                  r_state   <= W_IDLE;
                  r_bvalid  <= 1'b0;
                  r_bresp   <= RESP_OKAY;
                  r_awready <= 1'b1;
               end
            end
            default: r_state <= W_IDLE;
         endcase
      end
   end

   assign o_awready = r_awready;
   assign o_wready  = r_wready;
   assign o_bid     = r_wid;
   assign o_bresp   = r_bresp;
   assign o_bvalid  = r_bvalid;

endmodule

// File: rtl/axi_default_slave.sv
// Crossbar default slave: terminates every unmapped read and write with DECERR
// so the requesting master always gets a response. Read and write are independent.
module axi_default_slave
   import axi_pkg::*;
#(
   parameter int              ID_W       = AXI_IDS_BITS,
   parameter int              LEN_W      = AXI_LEN_BITS,
   parameter int              DATA_W     = AXI_DATA_BITS,
   parameter int              STRB_W     = AXI_STRB_BITS,
   parameter logic [DATA_W-1:0] RDATA_FILL = '0
) (
   input  logic              AXI_CLK_i,
   input  logic              AXI_RST_i,
   input  logic [ID_W-1:0]   ARID_i,
   input  logic [31:0]       ARADDR_i,
   input  logic [LEN_W-1:0]  ARLEN_i,
   input  logic [2:0]        ARSIZE_i,
   input  logic [1:0]        ARBURST_i,
   input  logic              ARVALID_i,
   output logic              ARREADY_o,
   output logic [ID_W-1:0]   RID_o,
   output logic [DATA_W-1:0] RDATA_o,
   output logic [1:0]        RRESP_o,
   output logic              RLAST_o,
   output logic              RVALID_o,
   input  logic              RREADY_i,
   input  logic [ID_W-1:0]   AWID_i,
   input  logic [31:0]       AWADDR_i,
   input  logic [LEN_W-1:0]  AWLEN_i,
   input  logic [2:0]        AWSIZE_i,
   input  logic [1:0]        AWBURST_i,
   input  logic              AWVALID_i,
   output logic              AWREADY_o,
   input  logic [DATA_W-1:0] WDATA_i,
   input  logic [STRB_W-1:0] WSTRB_i,
   input  logic              WLAST_i,
   input  logic              WVALID_i,
   output logic              WREADY_o,
   output logic [ID_W-1:0]   BID_o,
   output logic [1:0]        BRESP_o,
   output logic              BVALID_o,
   input  logic              BREADY_i
);

   // Address attributes and write payload carry no meaning for an error slave.
   logic w_unused_inputs;
   assign w_unused_inputs = ^{ARADDR_i, ARSIZE_i, ARBURST_i,
                              AWADDR_i, AWSIZE_i, AWBURST_i, WDATA_i, WSTRB_i};

   rd_state_e         r_rd_state;
   logic [LEN_W-1:0]  r_rcnt;
   logic [ID_W-1:0]   r_rid;
   logic              r_arready;
   logic              r_rvalid;
   logic              r_rlast;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_rresp;

   always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
      if (!AXI_RST_i) begin
         r_rd_state <= R_IDLE;
         r_rcnt     <= '0;
         r_rid      <= '0;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rlast    <= 1'b0;
         r_rdata    <= '0;
         r_rresp    <= RESP_OKAY;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (ARVALID_i && r_arready) begin
                  r_rd_state <= R_DATA;
                  r_rid      <= ARID_i;
                  r_rcnt     <= ARLEN_i;
                  r_arready  <= 1'b0;
                  r_rvalid   <= 1'b1;
                  r_rlast    <= (ARLEN_i == '0);
                  r_rdata    <= RDATA_FILL;
                  r_rresp    <= RESP_DECERR;
               end else begin
                  r_arready  <= 1'b1;
               end
            end
            R_DATA: begin
               if (RREADY_i) begin
                  if (r_rlast) begin
                     r_rd_state <= R_IDLE;
                     r_arready  <= 1'b1;
                     r_rvalid   <= 1'b0;
                     r_rlast    <= 1'b0;
                     r_rdata    <= '0;
                     r_rresp    <= RESP_OKAY;
                  end else begin
                     // RLAST is registered, so it is set when one beat remains.
                     r_rcnt  <= r_rcnt - 1'b1;
                     r_rlast <= (r_rcnt == LEN_W'(1));
                  end
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   assign ARREADY_o = r_arready;
   assign RID_o     = r_rid;
   assign RDATA_o   = r_rdata;
   assign RRESP_o   = r_rresp;
   assign RLAST_o   = r_rlast;
   assign RVALID_o  = r_rvalid;

   axi_default_slave_wr #(
      .ID_W  (ID_W),
      .LEN_W (LEN_W)
   ) u_wr (
      .i_clk     (AXI_CLK_i),
      .i_rst_n   (AXI_RST_i),
      .i_awid    (AWID_i),
      .i_awlen   (AWLEN_i),
      .i_awvalid (AWVALID_i),
      .o_awready (AWREADY_o),
      .i_wlast   (WLAST_i),
      .i_wvalid  (WVALID_i),
      .o_wready  (WREADY_o),
      .o_bid     (BID_o),
      .o_bresp   (BRESP_o),
      .o_bvalid  (BVALID_o),
      .i_bready  (BREADY_i)
   );

endmodule

// File: tb/tb_axi_default_slave.sv
// Self-checking bench for axi_default_slave: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the DECERR slave.
`timescale 1ns/1ps
module tb_axi_default_slave;

   localparam logic [31:0] FILL = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  arid, awid;
   logic [31:0] araddr, awaddr, wdata;
   logic [3:0]  arlen, awlen, wstrb;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst;
   logic        arvalid, rready, awvalid, wlast, wvalid, bready;
   logic        arready, rlast, rvalid, awready, wready, bvalid;
   logic [7:0]  rid, bid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   always #5 clk = ~clk;

   axi_default_slave dut (
      .AXI_CLK_i (clk),     .AXI_RST_i (rst_n),
      .ARID_i    (arid),    .ARADDR_i  (araddr),  .ARLEN_i   (arlen),
      .ARSIZE_i  (arsize),  .ARBURST_i (arburst), .ARVALID_i (arvalid),
      .ARREADY_o (arready), .RID_o     (rid),     .RDATA_o   (rdata),
      .RRESP_o   (rresp),   .RLAST_o   (rlast),   .RVALID_o  (rvalid),
      .RREADY_i  (rready),
      .AWID_i    (awid),    .AWADDR_i  (awaddr),  .AWLEN_i   (awlen),
      .AWSIZE_i  (awsize),  .AWBURST_i (awburst), .AWVALID_i (awvalid),
      .AWREADY_o (awready), .WDATA_i   (wdata),   .WSTRB_i   (wstrb),
      .WLAST_i   (wlast),   .WVALID_i  (wvalid),  .WREADY_o  (wready),
      .BID_o     (bid),     .BRESP_o   (bresp),   .BVALID_o  (bvalid),
      .BREADY_i  (bready)
   );

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: beats still owed on R, and write-transaction phase.
   int         m_r_left;
   logic [7:0] m_rid, m_wid;
   bit         m_aw_taken, m_b_pend, m_fresh;
   bit         ar_hs, r_hs, aw_hs, w_hs, b_hs;
   int         r_hs_cnt = 0;

   always @(negedge clk) begin
      bit exp_arready, exp_awready;
      if (!rst_n) begin
         check_val("reset_outs", {arready, rvalid, rlast, rresp, rid, rdata,
                                  awready, wready, bvalid, bresp, bid}, 64'd0);
         m_r_left = 0; m_aw_taken = 0; m_b_pend = 0; m_fresh = 1;
         ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      end else begin
         exp_arready = (m_r_left == 0) && !m_fresh;
         exp_awready = !m_aw_taken && !m_b_pend && !m_fresh;
         check_val("arready", arready, exp_arready);
         check_val("rvalid", rvalid, m_r_left > 0);
         if (m_r_left > 0) begin
            check_val("rid", rid, m_rid);
            check_val("rresp", rresp, 2'b11);
            check_val("rlast", rlast, m_r_left == 1);
            check_val("rdata", rdata, FILL);
         end
         check_val("awready", awready, exp_awready);
         check_val("wready", wready, m_aw_taken);
         check_val("bvalid", bvalid, m_b_pend);
         if (m_b_pend) begin
            check_val("bid", bid, m_wid);
            check_val("bresp", bresp, 2'b11);
         end
         ar_hs = arvalid && arready;
         r_hs  = rvalid && rready;
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         b_hs  = bvalid && bready;
         if (r_hs) r_hs_cnt++;
         if (m_r_left > 0) begin
            if (rready) m_r_left--;
         end else if (arvalid && exp_arready) begin
            m_r_left = int'(arlen) + 1;
            m_rid = arid;
         end
         if (m_b_pend) begin
            if (bready) m_b_pend = 0;
         end else if (m_aw_taken) begin
            if (wvalid && wlast) begin
               m_aw_taken = 0;
               m_b_pend = 1;
            end
         end else if (awvalid && exp_awready) begin
            m_aw_taken = 1;
            m_wid = awid;
         end
         m_fresh = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ar(input logic [7:0] id, input logic [3:0] len);
      int n = 0;
      arvalid = 1'b1; arid = id; arlen = len; araddr = $urandom;
      do begin step(); n++; end while (!ar_hs && n < 50);
      check_val("ar_accept", ar_hs, 1'b1);
      arvalid = 1'b0;
   endtask

   task automatic do_aw(input logic [7:0] id, input logic [3:0] len);
      int n = 0;
      awvalid = 1'b1; awid = id; awlen = len; awaddr = $urandom;
      do begin step(); n++; end while (!aw_hs && n < 50);
      check_val("aw_accept", aw_hs, 1'b1);
      awvalid = 1'b0;
   endtask

   task automatic do_w(input logic last);
      int n = 0;
      wvalid = 1'b1; wlast = last; wdata = $urandom; wstrb = 4'hf;
      do begin step(); n++; end while (!w_hs && n < 50);
      check_val("w_accept", w_hs, 1'b1);
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic wait_b();
      int n = 0;
      bready = 1'b1;
      do begin step(); n++; end while (!b_hs && n < 50);
      check_val("b_accept", b_hs, 1'b1);
      bready = 1'b0;
   endtask

   initial begin
      int c0, n;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
      wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
      repeat (3) step();
      rst_n = 1'b1;

      // Single-beat read straight after reset.
      rready = 1'b1;
      c0 = r_hs_cnt;
      do_ar(8'h15, 4'd0);
      repeat (2) step();
      check_val("rd1_beats", r_hs_cnt - c0, 1);

      // Four-beat read with RREADY toggling.
      c0 = r_hs_cnt;
      do_ar(8'h23, 4'd3);
      for (int i = 0; i < 8; i++) begin
         rready = (i % 2 == 0);
         step();
      end
      check_val("rd4_beats", r_hs_cnt - c0, 4);
      rready = 1'b1;
      step();

      // Two-beat write with B back-pressure.
      do_aw(8'h1A, 4'd1);
      do_w(1'b0);
      do_w(1'b1);
      bready = 1'b0;
      repeat (3) step();
      wait_b();
      step();

      // W presented before AW must wait for the AW handshake.
      wvalid = 1'b1; wlast = 1'b1; wdata = $urandom;
      repeat (3) step();
      do_aw(8'h2B, 4'd0);
      n = 0;
      do begin step(); n++; end while (!w_hs && n < 50);
      check_val("w_after_aw", n, 1);
      wvalid = 1'b0; wlast = 1'b0;
      wait_b();

      // Early WLAST still terminates the burst; next AW accepted.
      do_aw(8'h3C, 4'd3);
      do_w(1'b0);
      do_w(1'b1);
      wait_b();
      do_aw(8'h4D, 4'd0);
      do_w(1'b1);
      wait_b();

      // Maximum-length read burst.
      rready = 1'b1;
      c0 = r_hs_cnt;
      do_ar(8'h5E, 4'hf);
      repeat (17) step();
      check_val("rd16_beats", r_hs_cnt - c0, 16);

      // Simultaneous AR/AW, then asynchronous reset during R beat 2.
      arvalid = 1'b1; arid = 8'h61; arlen = 4'd2;
      awvalid = 1'b1; awid = 8'h62; awlen = 4'd0;
      step();
      check_val("sim_ar", ar_hs, 1'b1);
      check_val("sim_aw", aw_hs, 1'b1);
      arvalid = 1'b0; awvalid = 1'b0;
      step();
      #1 rst_n = 1'b0;
      #1 check_val("async_rst", {arready, rvalid, rlast, rresp, rid, rdata,
                                 awready, wready, bvalid, bresp, bid}, 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check_val("ready_after_rst", {arready, awready}, 2'b11);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         if (!arvalid || ar_hs) begin
            arvalid = ($urandom % 3 == 0);
            arid = 8'($urandom);
            arlen = ($urandom % 8 == 0) ? 4'hf : 4'($urandom % 4);
            araddr = $urandom;
         end
         rready = ($urandom % 4 != 0);
         if (!awvalid || aw_hs) begin
            awvalid = ($urandom % 3 == 0);
            awid = 8'($urandom);
            awlen = 4'($urandom % 16);
            awaddr = $urandom;
         end
         if (!wvalid || w_hs) begin
            wvalid = ($urandom % 2 == 0);
            wlast = ($urandom % 3 == 0);
            wdata = $urandom;
            wstrb = 4'($urandom);
         end
         bready = ($urandom % 2 == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
